// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared encodings and defaults for the memory stage
package mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int TIMEOUT_CYCLES_DEFAULT = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    // Halfwords need an even address, words a 4-byte aligned one; bytes never fault.
    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
        logic bad;
        bad = 1'b0;
        case (f3)
            F3_H, F3_HU: bad = off[0];
            F3_W:        bad = (off != 2'b00);
            default:     bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// rtl/mem_load_align.sv - lane select and sign/zero extension of load data
module mem_load_align
    import mem_pkg::*;
(
    input  logic [1:0]  off,
    input  logic [2:0]  funct3,
    input  logic [31:0] rdata,
    output logic [31:0] result
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    // Pick the addressed byte/half from the word and extend it to 32 bits.
    always_comb begin
        lane_b = 8'h00;
        case (off)
            2'd0: lane_b = rdata[7:0];
            2'd1: lane_b = rdata[15:8];
            2'd2: lane_b = rdata[23:16];
            2'd3: lane_b = rdata[31:24];
            default: lane_b = rdata[7:0];
        endcase
        lane_h = off[1] ? rdata[31:16] : rdata[15:0];
        case (funct3)
            F3_B:    result = {{24{lane_b[7]}}, lane_b};
            F3_H:    result = {{16{lane_h[15]}}, lane_h};
            F3_BU:   result = {24'h000000, lane_b};
            F3_HU:   result = {16'h0000, lane_h};
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - pipeline memory stage with req/ack data-memory handshake
module mem_stage
    import mem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic        ex_mem_read,
    input  logic        ex_mem_write,
    input  logic [2:0]  ex_funct3,
    input  logic [31:0] ex_alu_o,
    input  logic [31:0] ex_alu_o2,
    input  logic [31:0] ex_store_data,
    input  logic        ex_mop_en,
    input  logic [5:0]  ex_rd,
    input  logic        ex_mem2reg,
    input  logic        ex_regs_write,
    output logic [31:0] me_alu_o,
    output logic [31:0] me_alu_o2,
    output logic        me_mop_en,
    output logic [5:0]  me_rd,
    output logic        me_mem2reg,
    output logic        me_regs_write,
    output logic [31:0] me_mem_data,
    output logic        mem_stall,
    output logic        mem_err,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    output logic [3:0]  dm_be,
    input  logic        dm_ack,
    input  logic [31:0] dm_rdata
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    state_e      state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic        dm_req_q, dm_req_d;
    logic        dm_we_q, dm_we_d;
    logic [31:0] dm_addr_q, dm_addr_d;
    logic [31:0] dm_wdata_q, dm_wdata_d;
    logic [3:0]  dm_be_q, dm_be_d;
    logic [1:0]  off_q, off_d;
    logic [2:0]  f3_q, f3_d;
    logic [31:0] mem_data_q, mem_data_d;

    logic        mem_op;
    logic        is_store;
    logic        misal;
    logic        timeout_hit;
    logic [31:0] st_wdata;
    logic [3:0]  st_be;
    logic [31:0] load_result;

    mem_load_align u_align (
        .off    (off_q),
        .funct3 (f3_q),
        .rdata  (dm_rdata),
        .result (load_result)
    );

    // Classify the EX/MEM instruction; both read and write high counts as a load.
    always_comb begin
        mem_op      = ex_valid & (ex_mem_read | ex_mem_write);
        is_store    = ex_mem_write & ~ex_mem_read;
        misal       = mem_op & is_misaligned(ex_funct3, ex_alu_o[1:0]);
        timeout_hit = (cnt_q == CNT_LAST) & ~dm_ack;
    end

    // Store lane replication and byte enables by access size.
    always_comb begin
        st_wdata = ex_store_data;
        st_be    = 4'b1111;
        case (ex_funct3[1:0])
            2'b00: begin
                st_wdata = {4{ex_store_data[7:0]}};
                st_be    = 4'b0001 << ex_alu_o[1:0];
            end
            2'b01: begin
                st_wdata = {2{ex_store_data[15:0]}};
                st_be    = ex_alu_o[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                st_wdata = ex_store_data;
                st_be    = 4'b1111;
            end
        endcase
    end

    // Next-state and next-output computation for the access FSM.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dm_req_d   = dm_req_q;
        dm_we_d    = dm_we_q;
        dm_addr_d  = dm_addr_q;
        dm_wdata_d = dm_wdata_q;
        dm_be_d    = dm_be_q;
        off_d      = off_q;
        f3_d       = f3_q;
        mem_data_d = mem_data_q;
        case (state_q)
            IDLE: begin
                if (mem_op && !misal) begin
                    state_d    = BUSY;
                    cnt_d      = '0;
                    dm_req_d   = 1'b1;
                    dm_we_d    = is_store;
                    dm_addr_d  = {ex_alu_o[31:2], 2'b00};
                    dm_wdata_d = st_wdata;
                    dm_be_d    = st_be;
                    off_d      = ex_alu_o[1:0];
                    f3_d       = ex_funct3;
                end
            end
            BUSY: begin
                if (dm_ack) begin
                    state_d    = DONE;
                    dm_req_d   = 1'b0;
                    mem_data_d = load_result;
                end else if (timeout_hit) begin
                    state_d    = DONE;
                    dm_req_d   = 1'b0;
                    mem_data_d = 32'h0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d  = IDLE;
                dm_req_d = 1'b0;
            end
        endcase
    end

    // Register FSM state and the request bus held toward data memory.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            dm_req_q   <= 1'b0;
            dm_we_q    <= 1'b0;
            dm_addr_q  <= 32'h0;
            dm_wdata_q <= 32'h0;
            dm_be_q    <= 4'h0;
            off_q      <= 2'b00;
            f3_q       <= 3'b000;
            mem_data_q <= 32'h0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dm_req_q   <= dm_req_d;
            dm_we_q    <= dm_we_d;
            dm_addr_q  <= dm_addr_d;
            dm_wdata_q <= dm_wdata_d;
            dm_be_q    <= dm_be_d;
            off_q      <= off_d;
            f3_q       <= f3_d;
            mem_data_q <= mem_data_d;
        end
    end

    // Stall, error and writeback controls; all forced low while reset is held.
    always_comb begin
        mem_stall     = rst & (((state_q == IDLE) & mem_op & ~misal) | (state_q == BUSY));
        mem_err       = rst & (((state_q == IDLE) & misal) | ((state_q == BUSY) & timeout_hit));
        me_regs_write = rst & ex_valid & ex_regs_write & ~(ex_valid & is_store) & ~misal;
        me_mop_en     = rst & ex_mop_en;
        me_alu_o      = ex_alu_o;
        me_alu_o2     = ex_alu_o2;
        me_rd         = ex_rd;
        me_mem2reg    = ex_mem2reg;
        me_mem_data   = mem_data_q;
        dm_req        = dm_req_q;
        dm_we         = dm_we_q;
        dm_addr       = dm_addr_q;
        dm_wdata      = dm_wdata_q;
        dm_be         = dm_be_q;
    end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter TIMEOUT_CYCLES, 64, maximum BUSY cycles waiting for dm_ack before the access is abandoned.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 ex_valid  input  1  the EX/MEM register holds a valid instruction.
REQ-005 ex_mem_read, ex_mem_write  input  1 each  load op, store op; both high is treated as load.
REQ-006 ex_funct3  input  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU; BU/HU are loads only.
REQ-007 ex_alu_o, ex_alu_o2  input  32 each  ALU results; ex_alu_o is the effective address for memory ops.
REQ-008 ex_store_data  input  32  store source value.
REQ-009 ex_mop_en  input  1, ex_rd  input  6, ex_mem2reg  input  1, ex_regs_write  input  1  writeback control.
REQ-010 me_alu_o, me_alu_o2  output  32; me_mop_en  output  1; me_rd  output  6; me_mem2reg, me_regs_write  output  1  fields toward the MEM/WB register.
REQ-011 me_mem_data  output  32  aligned, extended load data (registered).
REQ-012 mem_stall  output  1  freezes PC, IF/ID, ID/EX and EX/MEM registers.
REQ-013 mem_err  output  1  one-cycle pulse: misaligned access or timeout.
REQ-014 dm_req, dm_we  output  1; dm_addr  output  32 (word-aligned, [1:0]=00); dm_wdata  output  32; dm_be  output  4.
REQ-015 dm_ack  input  1; dm_rdata  input  32  data-memory response, rdata valid with ack.

Function
REQ-016 FSM states IDLE, BUSY, DONE.
REQ-017 IDLE: memory op = ex_valid & (ex_mem_read | ex_mem_write); aligned op latches dm_addr/dm_we/dm_wdata/dm_be, moves to BUSY; mem_stall high combinationally that cycle.
REQ-018 Misaligned (H/HU with addr[0]=1; W with addr[1:0]!=0): no request, stays IDLE, mem_err pulses that cycle, me_regs_write forced 0, no stall.
REQ-019 BUSY: dm_req=1, address/data/be/we held stable until dm_ack; mem_stall=1; cycle counter increments.
REQ-020 BUSY with dm_ack: load result latched into me_mem_data, go DONE; dm_req falls next cycle.
REQ-021 BUSY with counter reaching TIMEOUT_CYCLES and no ack: mem_err pulse, me_mem_data=0, go DONE; ack in the same cycle wins (no error).
REQ-022 DONE: mem_stall=0 for one cycle so MEM/WB captures; then IDLE; dm_ack outside BUSY ignored.
REQ-023 Minimum memory-op latency: 2 stall cycles (ack on first BUSY cycle); non-memory ops: 0 stall cycles.
REQ-024 Store: SB wdata = byte replicated x4, be = 0001<<addr[1:0]; SH wdata = half replicated x2, be = 0011<<(2*addr[1]); SW be=1111.
REQ-025 Load: select byte/half by addr[1:0]; B/H sign-extend, BU/HU zero-extend; W unchanged.
REQ-026 me_alu_o, me_alu_o2, me_mop_en, me_rd, me_mem2reg pass through combinationally; me_regs_write = ex_valid & ex_regs_write, except REQ-018.
REQ-027 Stores never write a register regardless of ex_regs_write.

Reset
REQ-028 rst low: state IDLE, counter 0, dm_req/dm_we/dm_be/dm_addr/dm_wdata/me_mem_data/mem_err = 0 immediately.
REQ-029 rst low: mem_stall=0, me_regs_write=0, me_mop_en=0.
REQ-030 Reset mid-BUSY abandons the access; a late dm_ack after release is ignored.

Structure
REQ-031 Package mem_pkg holds funct3 encodings, FSM state encoding and TIMEOUT_CYCLES default.
REQ-032 One sub-module mem_load_align: combinational lane select and extension (addr[1:0], funct3, rdata -> 32-bit result).

Verification
REQ-033 LB addr 0x103, rdata 0x80AABBCC, ack first BUSY cycle -> me_mem_data 0xFFFFFF80, 2 stall cycles.
REQ-034 SH addr 0x102, store_data 0x1234ABCD -> dm_addr 0x100, dm_wdata 0xABCDABCD, dm_be 1100, dm_we 1.
REQ-035 LW addr 0x101 -> no dm_req, mem_err one cycle, me_regs_write 0, mem_stall 0.
REQ-036 LW, ack withheld, TIMEOUT_CYCLES=4 -> mem_err after 4 BUSY cycles, me_mem_data 0; ack at cycle 4 -> no error.
REQ-037 rst low during BUSY -> dm_req 0 and mem_stall 0 without clock edge; subsequent ack ignored.
REQ-038 LHU addr 0x102, rdata 0x8001FFFF, ack after 3 cycles -> me_mem_data 0x00008001, address stable throughout.
